// File: rtl/decoder38_pkg.sv
// Shared types and constants for the 3-to-8 round-robin grant decoder.
// Holds the FSM state enum, inactive output patterns and the round-robin search helper.
package decoder38_pkg;

  localparam int unsigned NUM_CH        = 8;
  localparam logic [7:0]  Y_INACTIVE_HI = 8'h00;
  localparam logic [7:0]  Y_INACTIVE_LO = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  // First set request at or after last+1, wrapping modulo 8; k=8 lands back on last.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = last + 3'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/dec38_pol.sv
// Polarity-selectable 3-to-8 decoder: one-hot (s=1) or one-cold (s=0) when enabled,
// otherwise the inactive pattern for the selected polarity.
module dec38_pol
  import decoder38_pkg::*;
(
  input  logic       en,
  input  logic       s,
  input  logic [2:0] w,
  output logic [7:0] y
);

  logic [7:0] onehot;

  always_comb begin
    onehot = 8'h01 << w;
    y      = s ? Y_INACTIVE_HI : Y_INACTIVE_LO;
    if (en) begin
      y = s ? onehot : ~onehot;
    end
  end

endmodule

// File: rtl/decoder38_rr_arbiter.sv
// 8-channel round-robin arbiter with IDLE/GRANT/GAP FSM and polarity-selectable grant lines.
// Optional per-owner hold limit enabled by defining HOLD_TIMEOUT_EN (limit = MAX_HOLD cycles).
module decoder38_rr_arbiter
  import decoder38_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       e,
  input  logic       s,
  output logic [2:0] w,
  output logic [7:0] y,
  output logic       busy
);

  state_t     state_q;
  logic [2:0] w_q;
  logic [2:0] last_q;
  logic       busy_q;
  logic [2:0] owner_d;
  logic       release_d;
  logic       timeout;

`ifdef HOLD_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  logic [3:0] hold_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else if (state_q == IDLE && !e && (req != '0)) begin
      hold_cnt_q <= '0;
    end else if (state_q == GRANT) begin
      hold_cnt_q <= hold_cnt_q + 4'd1;
    end
  end

  assign timeout = (hold_cnt_q == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    owner_d   = rr_pick(req, last_q);
    release_d = done | ~req[w_q] | timeout;
  end

  // Disable takes priority over any release, so last is not updated on an e-abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      last_q  <= 3'd7;
      busy_q  <= 1'b0;
    end else if (e) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req != '0) begin
            state_q <= GRANT;
            w_q     <= owner_d;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q <= GAP;
            last_q  <= w_q;
            busy_q  <= 1'b0;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign w    = w_q;
  assign busy = busy_q;

  dec38_pol u_pol (
    .en (state_q == GRANT),
    .s  (s),
    .w  (w_q),
    .y  (y)
  );

endmodule

// File: tb/tb_decoder38_rr_arbiter.sv
// Self-checking bench for decoder38_rr_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the arbitration rules.
module tb_decoder38_rr_arbiter;

`ifdef HOLD_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 15;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       e = 1'b0;
  logic       s = 1'b1;
  logic [2:0] w;
  logic [7:0] y;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  // Model: phase 0=idle, 1=granting, 2=gap
  int m_phase;
  int m_owner;
  int m_last;
  int m_held;

  decoder38_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .done (done),
    .e    (e),
    .s    (s),
    .w    (w),
    .y    (y),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = 0;
    m_last  = 7;
    m_held  = 0;
  endtask

  function automatic int search(input logic [7:0] r, input int last);
    int pick;
    pick = -1;
    for (int k = 1; k <= 8; k++) begin
      if (pick < 0 && r[(last + k) % 8]) pick = (last + k) % 8;
    end
    return pick;
  endfunction

  task automatic model_edge();
    bit timed_out;
`ifdef HOLD_TIMEOUT_EN
    timed_out = (m_held + 1 >= MH);
`else
    timed_out = 1'b0;
`endif
    if (e) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (req != 8'h00) begin
        m_owner = search(req, m_last);
        m_phase = 1;
        m_held  = 0;
      end
    end else if (m_phase == 1) begin
      if (done || !req[m_owner] || timed_out) begin
        m_last  = m_owner;
        m_phase = 2;
      end else begin
        m_held++;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  function automatic logic [7:0] exp_y();
    logic [7:0] v;
    if (m_phase == 1) v = s ? 8'(1 << m_owner) : ~8'(1 << m_owner);
    else              v = s ? 8'h00 : 8'hFF;
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".y"}, y, exp_y());
    chk({tag, ".w"}, {5'd0, w}, 8'(m_owner));
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, m_phase == 1});
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick("rst_a");
    tick("rst_b");
  endtask

  initial begin
    // Reset state and same-cycle repolarisation
    model_reset();
    s = 1'b1; req = 8'h00;
    tick("rst0");
    chk("rst.y_hi", y, 8'h00);
    chk("rst.busy", {7'd0, busy}, 8'h00);
    s = 1'b0;
    #1;
    chk("rst.y_lo", y, 8'hFF);
    check_all("rst_s0");

    // req=24: grant 2, release, then grant 5
    s = 1'b1; req = 8'h24;
    rst = 1'b0;
    tick("g2");
    chk("g2.y", y, 8'h04);
    chk("g2.w", {5'd0, w}, 8'd2);
    done = 1'b1;
    tick("gap_after2");
    chk("gap.y", y, 8'h00);
    done = 1'b0;
    tick("idle_after2");
    tick("g5");
    chk("g5.y", y, 8'h20);
    chk("g5.w", {5'd0, w}, 8'd5);
    req = 8'h2C;
    tick("g5_hold");
    chk("g5_hold.w", {5'd0, w}, 8'd5);
    req = 8'h0C; done = 1'b1;
    tick("g5_rel");
    done = 1'b0;
    tick("idle_b");
    tick("g_wrap2");
    chk("wrap2.w", {5'd0, w}, 8'd2);

    // Fairness and wrap-around with all requests
    do_reset();
    req = 8'hFF; done = 1'b0; rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick("rr_grant");
      chk("rr.w", {5'd0, w}, 8'(i % 8));
      done = 1'b1;
      tick("rr_gap");
      done = 1'b0;
      tick("rr_idle");
    end

    // Disable during active-low grant of channel 3; last held so F0 resumes at 4
    s = 1'b0; req = 8'h08;
    do_reset();
    rst = 1'b0;
    tick("g3");
    chk("g3.y", y, 8'hF7);
    req = 8'hF0; e = 1'b1;
    tick("dis");
    chk("dis.y", y, 8'hFF);
    chk("dis.busy", {7'd0, busy}, 8'h00);
    e = 1'b0;
    tick("g4");
    chk("g4.w", {5'd0, w}, 8'd4);
    chk("g4.y", y, 8'hEF);

    // Asynchronous reset during grant of channel 6
    s = 1'b1; req = 8'h40;
    do_reset();
    rst = 1'b0;
    tick("g6");
    chk("g6.w", {5'd0, w}, 8'd6);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst.y", y, 8'h00);
    chk("arst.busy", {7'd0, busy}, 8'h00);
    check_all("arst");
    tick("arst_hold");
    rst = 1'b0; req = 8'hC0;
    tick("g6b");
    chk("g6b.w", {5'd0, w}, 8'd6);

    // Hold behaviour with a single request held and no done
    do_reset();
    req = 8'h01; done = 1'b0; s = 1'b1; rst = 1'b0;
    tick("hold_g");
`ifdef HOLD_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick("hold_on");
      chk("hold_on.busy", {7'd0, busy}, 8'h01);
    end
    tick("hold_gap");
    chk("hold_gap.busy", {7'd0, busy}, 8'h00);
    tick("hold_idle");
    tick("hold_regrant");
    chk("hold_regrant.y", y, 8'h01);
`else
    for (int i = 0; i < 20; i++) tick("hold_unbounded");
    chk("unbounded.busy", {7'd0, busy}, 8'h01);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      done = ($urandom_range(0, 3) == 0);
      e    = ($urandom_range(0, 9) == 0);
      s    = 1'($urandom);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
